// File: rtl/vga_pkg.sv
// Shared types, timing defaults and geometry helpers for the VGA scanout.
// Optional feature macro: VGA_SCAN_BORDER_EN (adds the border flag to scan_flags_t).
package vga_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    // Per-pixel flags that travel alongside the RAM read.
    typedef struct packed {
        logic active;
        logic in_win;
        logic hs;
        logic vs;
        logic vblank;
        logic first;
`ifdef VGA_SCAN_BORDER_EN
        logic rim;
`endif
    } scan_flags_t;

    function automatic int line_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    function automatic int win_off(input int vis, input int fb, input int scale);
        return (vis - fb * scale) / 2;
    endfunction

    function automatic scan_flags_t flags_idle();
        scan_flags_t f;
        f        = '0;
        f.vblank = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters, raw sync/visibility flags and framebuffer address generation.
// Optional feature macro: VGA_SCAN_BORDER_EN (adds the rim flag output).
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS  = DEF_H_VIS,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_VIS  = DEF_V_VIS,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int SCALE  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    active,
    output logic                    in_window,
    output logic                    hs_on,
    output logic                    vs_on,
    output logic                    vblank,
    output logic                    first_px,
`ifdef VGA_SCAN_BORDER_EN
    output logic                    rim,
`endif
    output logic [$clog2(FB_W)-1:0] x_a,
    output logic [$clog2(FB_H)-1:0] y_a
);

    localparam int H_TOTAL = line_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(FB_W);
    localparam int YW      = $clog2(FB_H);
    localparam int X_OFF   = win_off(H_VIS, FB_W, SCALE);
    localparam int Y_OFF   = win_off(V_VIS, FB_H, SCALE);
    localparam int X_SPAN  = FB_W * SCALE;
    localparam int Y_SPAN  = FB_H * SCALE;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [1:0]    SUB_LAST = 2'(SCALE - 1);

    logic [HW-1:0] hcnt_r, h_nx_s;
    logic [VW-1:0] vcnt_r, v_nx_s;
    logic [XW-1:0] x_r, x_nx_s;
    logic [YW-1:0] yl_r, yl_nx_s, y_a_r;
    logic [1:0]    xsub_r, xsub_nx_s, ysub_r, ysub_nx_s;
    logic          h_wrap_s, win_nx_s;

    function automatic logic in_x(input logic [HW-1:0] h);
        return (int'(h) >= X_OFF) && (int'(h) < X_OFF + X_SPAN);
    endfunction

    function automatic logic in_y(input logic [VW-1:0] v);
        return (int'(v) >= Y_OFF) && (int'(v) < Y_OFF + Y_SPAN);
    endfunction

    // Next raster position; addresses are computed for that position so they line up with it.
    always_comb begin
        h_wrap_s = (hcnt_r == H_LAST);
        h_nx_s   = h_wrap_s ? '0 : hcnt_r + HW'(1);
        if (h_wrap_s) begin
            v_nx_s = (vcnt_r == V_LAST) ? '0 : vcnt_r + VW'(1);
        end else begin
            v_nx_s = vcnt_r;
        end
        win_nx_s = in_x(h_nx_s) && in_y(v_nx_s);
    end

    // Row counter steps once per SCALE lines while inside the window rows.
    always_comb begin
        yl_nx_s   = yl_r;
        ysub_nx_s = ysub_r;
        if (!h_wrap_s) begin
            yl_nx_s   = yl_r;
            ysub_nx_s = ysub_r;
        end else if (!in_y(v_nx_s) || (int'(v_nx_s) == Y_OFF)) begin
            yl_nx_s   = '0;
            ysub_nx_s = 2'd0;
        end else if (ysub_r == SUB_LAST) begin
            yl_nx_s   = yl_r + YW'(1);
            ysub_nx_s = 2'd0;
        end else begin
            ysub_nx_s = ysub_r + 2'd1;
        end
    end

    // Column counter steps once per SCALE pixels inside the window, zero elsewhere.
    always_comb begin
        x_nx_s    = x_r;
        xsub_nx_s = xsub_r;
        if (!win_nx_s || (int'(h_nx_s) == X_OFF)) begin
            x_nx_s    = '0;
            xsub_nx_s = 2'd0;
        end else if (xsub_r == SUB_LAST) begin
            x_nx_s    = x_r + XW'(1);
            xsub_nx_s = 2'd0;
        end else begin
            xsub_nx_s = xsub_r + 2'd1;
        end
    end

    // Counter and address state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_r <= '0;
            vcnt_r <= '0;
            x_r    <= '0;
            xsub_r <= 2'd0;
            yl_r   <= '0;
            ysub_r <= 2'd0;
            y_a_r  <= '0;
        end else begin
            hcnt_r <= h_nx_s;
            vcnt_r <= v_nx_s;
            x_r    <= x_nx_s;
            xsub_r <= xsub_nx_s;
            yl_r   <= yl_nx_s;
            ysub_r <= ysub_nx_s;
            y_a_r  <= win_nx_s ? yl_nx_s : '0;
        end
    end

    assign x_a       = x_r;
    assign y_a       = y_a_r;
    assign active    = (int'(hcnt_r) < H_VIS) && (int'(vcnt_r) < V_VIS);
    assign in_window = in_x(hcnt_r) && in_y(vcnt_r);
    assign hs_on     = (int'(hcnt_r) >= H_VIS + H_FP) && (int'(hcnt_r) < H_VIS + H_FP + H_SYNC);
    assign vs_on     = (int'(vcnt_r) >= V_VIS + V_FP) && (int'(vcnt_r) < V_VIS + V_FP + V_SYNC);
    assign vblank    = (int'(vcnt_r) >= V_VIS);
    assign first_px  = (hcnt_r == '0) && (vcnt_r == '0);
`ifdef VGA_SCAN_BORDER_EN
    assign rim = active && ((int'(hcnt_r) == 0) || (int'(hcnt_r) == H_VIS - 1) ||
                            (int'(vcnt_r) == 0) || (int'(vcnt_r) == V_VIS - 1));
`endif

endmodule

// File: rtl/vga_scan.sv
// Parametrised VGA scanout: timing, RAM-latency-matched flag pipeline and colour mux.
// Optional feature macro: VGA_SCAN_BORDER_EN (border_col input, outer frame and surround).
module vga_scan
    import vga_pkg::*;
#(
    parameter int H_VIS    = DEF_H_VIS,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_VIS    = DEF_V_VIS,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0,
    parameter int FB_W     = 320,
    parameter int FB_H     = 240,
    parameter int SCALE    = 2,
    parameter int PIX_BITS = 1,
    parameter int RAM_LAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [$clog2(FB_W)-1:0] x_a,
    output logic [$clog2(FB_H)-1:0] y_a,
    input  logic [PIX_BITS-1:0]     in_a,
    input  logic [7:0]              fg,
    input  logic [7:0]              bg,
`ifdef VGA_SCAN_BORDER_EN
    input  logic [7:0]              border_col,
`endif
    output logic                    HS,
    output logic                    VS,
    output logic [2:0]              R,
    output logic [2:0]              G,
    output logic [1:0]              B,
    output logic                    vblank,
    output logic                    frame_start
);

    localparam logic        SYNC_ACT   = (SYNC_POL != 0);
    localparam scan_flags_t FLAGS_IDLE = flags_idle();

    if ((PIX_BITS != 1) && (PIX_BITS != 8)) begin : g_bad_pix
        $error("vga_scan: PIX_BITS must be 1 or 8");
    end
    if ((SCALE < 1) || (SCALE > 4)) begin : g_bad_scale
        $error("vga_scan: SCALE must be 1..4");
    end
    if ((RAM_LAT < 1) || (RAM_LAT > 3)) begin : g_bad_lat
        $error("vga_scan: RAM_LAT must be 1..3");
    end
    if ((FB_W * SCALE > H_VIS) || (FB_H * SCALE > V_VIS)) begin : g_bad_fit
        $error("vga_scan: scaled framebuffer exceeds visible area");
    end

    logic        active_s, in_window_s, hs_on_s, vs_on_s, vblank_s, first_s;
    scan_flags_t cur_s, tail_s;
    scan_flags_t dly_r [RAM_LAT];
    rgb332_t     pix_s, col_s;
`ifdef VGA_SCAN_BORDER_EN
    logic        rim_s;
`endif

    vga_timing #(
        .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .FB_W  (FB_W),  .FB_H (FB_H), .SCALE  (SCALE)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .active    (active_s),
        .in_window (in_window_s),
        .hs_on     (hs_on_s),
        .vs_on     (vs_on_s),
        .vblank    (vblank_s),
        .first_px  (first_s),
`ifdef VGA_SCAN_BORDER_EN
        .rim       (rim_s),
`endif
        .x_a       (x_a),
        .y_a       (y_a)
    );

    // Gather counter-stage flags into one bundle.
    always_comb begin
        cur_s        = FLAGS_IDLE;
        cur_s.active = active_s;
        cur_s.in_win = in_window_s;
        cur_s.hs     = hs_on_s;
        cur_s.vs     = vs_on_s;
        cur_s.vblank = vblank_s;
        cur_s.first  = first_s;
`ifdef VGA_SCAN_BORDER_EN
        cur_s.rim    = rim_s;
`endif
    end

    // Delay flags by the RAM latency so they meet in_a for the same pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                dly_r[i] <= FLAGS_IDLE;
            end
        end else begin
            dly_r[0] <= cur_s;
            for (int i = 1; i < RAM_LAT; i++) begin
                dly_r[i] <= dly_r[i-1];
            end
        end
    end

    assign tail_s = dly_r[RAM_LAT-1];

    if (PIX_BITS == 1) begin : g_mono
        assign pix_s = in_a[0] ? rgb332_t'(fg) : rgb332_t'(bg);
    end else begin : g_direct
        logic unused_fg_s;
        assign unused_fg_s = ^fg;
        assign pix_s       = rgb332_t'(in_a);
    end

    // Colour selection for the pixel leaving the delay line.
    always_comb begin
        col_s = '0;
        if (!tail_s.active) begin
            col_s = '0;
`ifdef VGA_SCAN_BORDER_EN
        end else if (tail_s.rim) begin
            col_s = rgb332_t'(border_col);
        end else if (tail_s.in_win) begin
            col_s = pix_s;
        end else begin
            col_s = rgb332_t'(border_col);
        end
`else
        end else if (tail_s.in_win) begin
            col_s = pix_s;
        end else begin
            col_s = rgb332_t'(bg);
        end
`endif
    end

    // Output register stage driving the connector pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HS          <= ~SYNC_ACT;
            VS          <= ~SYNC_ACT;
            R           <= 3'd0;
            G           <= 3'd0;
            B           <= 2'd0;
            vblank      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            HS          <= tail_s.hs ? SYNC_ACT : ~SYNC_ACT;
            VS          <= tail_s.vs ? SYNC_ACT : ~SYNC_ACT;
            R           <= col_s.r;
            G           <= col_s.g;
            B           <= col_s.b;
            vblank      <= tail_s.vblank;
            frame_start <= tail_s.first;
        end
    end

endmodule
